// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the pattern step sequencer.
package note_sequencer_pkg;

   localparam int SEQ_DUR_W  = 16;
   localparam int SEQ_FREQ_W = 16;

   localparam int              DIV_48KHZ  = 260;
   localparam logic [15:0]     FREQ_440HZ = 16'd4723;

   localparam logic [1:0] SEQ_IDLE = 2'd0;
   localparam logic [1:0] SEQ_LOAD = 2'd1;
   localparam logic [1:0] SEQ_PLAY = 2'd2;
   localparam logic [1:0] SEQ_GAP  = 2'd3;

   typedef struct packed {
      logic                  rest;
      logic [SEQ_DUR_W-1:0]  dur;
      logic [SEQ_FREQ_W-1:0] freq;
   } step_t;

endpackage

// File: rtl/note_sequencer_ram.sv
// Pattern store: one write port, one registered read port, read-first on address collision.
module note_sequencer_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 33,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer feeding an oscillator freq word from a stored pattern on the sample-tick grid.
// Holds the tick divider, play FSM, duration/gap counters and registered outputs.
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int DIV       = DIV_48KHZ,
   parameter int GAP_TICKS = 48,
   parameter int FREQ_W    = 16,
   parameter int DUR_W     = 16,
   localparam int AW       = $clog2(DEPTH),
   localparam int SW       = 1 + DUR_W + FREQ_W
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [SW-1:0]     wr_data_i,
   input  logic [AW:0]       len_i,
   input  logic              loop_i,
   input  logic              start_i,
   input  logic              stop_i,
   output logic [FREQ_W-1:0] freq_o,
   output logic              gate_o,
   output logic [AW-1:0]     step_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   logic [CW-1:0]    cnt;
   logic             tick;
   logic [1:0]       state;
   logic             pend;
   logic [AW-1:0]    step;
   logic [AW:0]      len;
   logic             loop_en;
   logic             cur_rest;
   logic [DUR_W-1:0] dcnt;
   logic [GW-1:0]    gcnt;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [SW-1:0]    rd_data;
   logic             last_step;
   logic             gap_needed;
   logic             advance;
   logic [AW:0]      len_clamped;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cnt <= '0;
      else         cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
   end

   assign tick        = (cnt == CW'(DIV - 1));
   assign tick_o      = tick;
   assign step_o      = step;
   assign busy_o      = (state != SEQ_IDLE);
   assign len_clamped = (len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len_i;
   assign last_step   = ((AW+1)'(step) + (AW+1)'(1)) >= len;
   assign gap_needed  = !cur_rest && (GAP_TICKS > 0);
   assign advance     = tick && ((state == SEQ_PLAY && dcnt == DUR_W'(1) && !gap_needed) ||
                                 (state == SEQ_GAP && gcnt == GW'(1)));

   // The next step's read is issued on the ending tick so its data lands while in LOAD.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      if (!stop_i && !start_i && tick) begin
         if (state == SEQ_LOAD && pend) begin
            rd_en   = 1'b1;
            rd_addr = step;
         end else if (advance) begin
            rd_en   = 1'b1;
            rd_addr = last_step ? '0 : step + 1'b1;
         end
      end
   end

   note_sequencer_ram #(.DEPTH(DEPTH), .W(SW)) u_ram (
      .clk     (clk_i),
      .wr_en   (wr_en_i),
      .wr_addr (wr_addr_i),
      .wr_data (wr_data_i),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= SEQ_IDLE;
         pend     <= 1'b0;
         step     <= '0;
         len      <= '0;
         loop_en  <= 1'b0;
         cur_rest <= 1'b0;
         dcnt     <= '0;
         gcnt     <= '0;
         freq_o   <= '0;
         gate_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (stop_i) begin
            state  <= SEQ_IDLE;
            pend   <= 1'b0;
            gate_o <= 1'b0;
         end else if (start_i) begin
            gate_o <= 1'b0;
            if (len_i == '0) begin
               state  <= SEQ_IDLE;
               pend   <= 1'b0;
               done_o <= 1'b1;
            end else begin
               state   <= SEQ_LOAD;
               pend    <= 1'b1;
               step    <= '0;
               len     <= len_clamped;
               loop_en <= loop_i;
            end
         end else begin
            case (state)
               SEQ_LOAD: begin
                  if (pend) begin
                     if (tick) pend <= 1'b0;
                  end else begin
                     freq_o   <= rd_data[FREQ_W-1:0];
                     gate_o   <= ~rd_data[SW-1];
                     cur_rest <= rd_data[SW-1];
                     dcnt     <= (rd_data[FREQ_W +: DUR_W] == '0) ? DUR_W'(1)
                                                                   : rd_data[FREQ_W +: DUR_W];
                     state    <= SEQ_PLAY;
                  end
               end
               SEQ_PLAY: begin
                  if (tick && dcnt != DUR_W'(1)) begin
                     dcnt <= dcnt - 1'b1;
                  end else if (tick && gap_needed) begin
                     gate_o <= 1'b0;
                     gcnt   <= GW'(GAP_TICKS);
                     state  <= SEQ_GAP;
                  end
               end
               SEQ_GAP: begin
                  if (tick && gcnt != GW'(1)) gcnt <= gcnt - 1'b1;
               end
               default: ;
            endcase

            if (advance) begin
               if (!last_step) begin
                  step  <= step + 1'b1;
                  state <= SEQ_LOAD;
               end else if (loop_en) begin
                  step  <= '0;
                  state <= SEQ_LOAD;
               end else begin
                  gate_o <= 1'b0;
                  done_o <= 1'b1;
                  state  <= SEQ_IDLE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: pattern playback checked tick by tick against a step-list model.
`timescale 1ns/1ps
module tb_note_sequencer;
   import note_sequencer_pkg::*;

   localparam int DEPTH = 16;
   localparam int DIV   = 4;
   localparam int GAP   = 2;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   step_t         wr_data = '0;
   logic [AW:0]   len = '0;
   logic          loop_v = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [15:0]   freq_o;
   logic          gate_o;
   logic [AW-1:0] step_o;
   logic          busy_o;
   logic          done_o;
   logic          tick_o;

   int    checks = 0;
   int    failures = 0;
   int    done_cnt = 0;
   step_t m_mem [DEPTH];

   note_sequencer #(.DEPTH(DEPTH), .DIV(DIV), .GAP_TICKS(GAP), .FREQ_W(16), .DUR_W(16)) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .len_i     (len),
      .loop_i    (loop_v),
      .start_i   (start),
      .stop_i    (stop),
      .freq_o    (freq_o),
      .gate_o    (gate_o),
      .step_o    (step_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .tick_o    (tick_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done_o === 1'b1) done_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (tick_o !== 1'b1 && n < 2*DIV) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tick_o !== 1'b1) begin
         failures++;
         $display("FAIL tick_wait tick_o=%b required=1", tick_o);
      end
   endtask

   task automatic write_step(input int addr, input step_t s);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = s;
      @(negedge clk);
      wr_en = 1'b0;
      m_mem[addr] = s;
   endtask

   task automatic pulse_start(input int n, input bit lp);
      @(negedge clk);
      start = 1'b1; len = (AW+1)'(n); loop_v = lp;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sync_first_tick();
      if (tick_o !== 1'b1) wait_tick();
   endtask

   function automatic int step_ticks(input step_t s);
      int d = (s.dur == 0) ? 1 : int'(s.dur);
      return s.rest ? d : d + GAP;
   endfunction

   // Samples at tick cycles [first, last) of one step: note ticks then gap ticks.
   task automatic check_step(input step_t s, input int idx, input int first, input int last);
      int d = (s.dur == 0) ? 1 : int'(s.dur);
      logic exp_gate;
      for (int t = first; t < last; t++) begin
         wait_tick();
         exp_gate = !s.rest && (t < d);
         checks++;
         if (gate_o !== exp_gate) begin
            failures++;
            $display("FAIL gate step%0d tick%0d got=%b want=%b", idx, t, gate_o, exp_gate);
         end
         checks++;
         if (freq_o !== s.freq) begin
            failures++;
            $display("FAIL freq step%0d tick%0d got=%0d want=%0d", idx, t, freq_o, s.freq);
         end
         checks++;
         if (step_o !== AW'(idx)) begin
            failures++;
            $display("FAIL step_idx tick%0d got=%0d want=%0d", t, step_o, idx);
         end
      end
   endtask

   task automatic play(input int n_steps, input int plen);
      int idx = 0;
      for (int k = 0; k < n_steps; k++) begin
         check_step(m_mem[idx], idx, 0, step_ticks(m_mem[idx]));
         idx = (idx + 1 < plen) ? idx + 1 : 0;
      end
   endtask

   task automatic expect_end(input string name);
      @(negedge clk);
      checks++;
      if (done_o !== 1'b1) begin failures++; $display("FAIL %s_done got=%b want=1", name, done_o); end
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL %s_busy got=%b want=0", name, busy_o); end
      checks++;
      if (gate_o !== 1'b0) begin failures++; $display("FAIL %s_gate got=%b want=0", name, gate_o); end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b want=0", name, done_o); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({freq_o, gate_o, step_o, busy_o, done_o, tick_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {freq_o, gate_o, step_o, busy_o, done_o, tick_o});
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({gate_o, busy_o, done_o} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset got=%b want=000", {gate_o, busy_o, done_o});
      end
   endtask

   task automatic test_divider();
      int n;
      wait_tick();
      for (int r = 0; r < 3; r++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (tick_o !== 1'b1 && n < 3*DIV);
         checks++;
         if (n != DIV) begin failures++; $display("FAIL tick_period got=%0d want=%0d", n, DIV); end
      end
   endtask

   task automatic test_basic();
      step_t s;
      s = '{rest: 1'b0, dur: 16'd3, freq: FREQ_440HZ}; write_step(0, s);
      s = '{rest: 1'b0, dur: 16'd2, freq: 16'd5000};   write_step(1, s);
      s = '{rest: 1'b1, dur: 16'd1, freq: 16'd0};      write_step(2, s);
      pulse_start(3, 1'b0);
      sync_first_tick();
      play(3, 3);
      expect_end("basic");
   endtask

   task automatic test_loop();
      int d0 = done_cnt;
      pulse_start(3, 1'b1);
      sync_first_tick();
      play(4, 3);
      check_step(m_mem[1], 1, 0, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if (gate_o !== 1'b0) begin failures++; $display("FAIL stop_gate got=%b want=0", gate_o); end
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b want=0", busy_o); end
      @(negedge clk);
      checks++;
      if (done_cnt != d0) begin failures++; $display("FAIL loop_no_done got=%0d want=%0d", done_cnt, d0); end
   endtask

   task automatic test_dur0_len0();
      step_t s;
      s = '{rest: 1'b0, dur: 16'd0, freq: 16'd111}; write_step(5, s);
      @(negedge clk);
      start = 1'b1; len = '0; loop_v = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done_o !== 1'b1) begin failures++; $display("FAIL len0_done got=%b want=1", done_o); end
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b want=0", busy_o); end
      s = '{rest: 1'b0, dur: 16'd0, freq: 16'd777}; write_step(0, s);
      pulse_start(1, 1'b0);
      sync_first_tick();
      play(1, 1);
      expect_end("dur0");
   endtask

   task automatic test_overwrite();
      step_t s;
      step_t s1old;
      s = '{rest: 1'b0, dur: 16'd1, freq: 16'd1000}; write_step(0, s);
      s = '{rest: 1'b0, dur: 16'd3, freq: 16'd2000}; write_step(1, s);
      s = '{rest: 1'b1, dur: 16'd1, freq: 16'd3000}; write_step(2, s);
      pulse_start(3, 1'b1);
      sync_first_tick();
      check_step(m_mem[0], 0, 0, step_ticks(m_mem[0]));
      s1old = m_mem[1];
      check_step(s1old, 1, 0, 1);
      s = '{rest: 1'b0, dur: 16'd2, freq: 16'd2500}; write_step(1, s);
      check_step(s1old, 1, 1, step_ticks(s1old));
      check_step(m_mem[2], 2, 0, step_ticks(m_mem[2]));
      check_step(m_mem[0], 0, 0, step_ticks(m_mem[0]));
      check_step(m_mem[1], 1, 0, step_ticks(m_mem[1]));
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic test_start_stop();
      @(negedge clk);
      start = 1'b1; stop = 1'b1; len = 5'd3; loop_v = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (busy_o !== 1'b0) begin failures++; $display("FAIL startstop_idle_busy got=%b want=0", busy_o); end
         @(negedge clk);
      end
      pulse_start(3, 1'b1);
      sync_first_tick();
      check_step(m_mem[0], 0, 0, 1);
      @(negedge clk);
      pulse_start(2, 1'b1);
      checks++;
      if (gate_o !== 1'b0) begin failures++; $display("FAIL restart_gate got=%b want=0", gate_o); end
      checks++;
      if (busy_o !== 1'b1 || step_o !== '0) begin
         failures++;
         $display("FAIL restart_state busy=%b step=%0d want busy=1 step=0", busy_o, step_o);
      end
      sync_first_tick();
      play(3, 2);
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || gate_o !== 1'b0) begin
         failures++;
         $display("FAIL startstop_play busy=%b gate=%b want 0 0", busy_o, gate_o);
      end
   endtask

   task automatic test_clamp();
      step_t s;
      for (int i = 0; i < DEPTH; i++) begin
         s = '{rest: 1'b1, dur: 16'd1, freq: 16'($urandom)};
         write_step(i, s);
      end
      pulse_start(31, 1'b0);
      sync_first_tick();
      play(DEPTH, DEPTH);
      expect_end("clamp");
   endtask

   task automatic test_reset_in_gap();
      step_t s;
      s = '{rest: 1'b0, dur: 16'd2, freq: 16'd4321}; write_step(0, s);
      pulse_start(1, 1'b0);
      sync_first_tick();
      check_step(m_mem[0], 0, 0, 3);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if ({freq_o, gate_o, step_o, busy_o, done_o, tick_o} !== '0) begin
         failures++;
         $display("FAIL reset_in_gap got=%h want=0", {freq_o, gate_o, step_o, busy_o, done_o, tick_o});
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_random();
      step_t s;
      int n;
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            s.rest = ($urandom_range(0, 3) == 0);
            s.dur  = 16'($urandom_range(0, 3));
            s.freq = 16'($urandom);
            write_step(i, s);
         end
         pulse_start(n, 1'b0);
         sync_first_tick();
         play(n, n);
         expect_end("random");
      end
   endtask

   initial begin
      test_reset();
      test_divider();
      test_basic();
      test_loop();
      test_dur0_len0();
      test_overwrite();
      test_start_stop();
      test_clamp();
      test_reset_in_gap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
